// File: rtl/cr_kme_fifo_reader.sv
// Drains DATA_SIZE-bit entries from a KME staging FIFO and serializes each one
// into BEAT_W-bit beats on a valid/ready stream, counting completed words.
//
//   state | meaning
//   IDLE  | no word held; pops when enabled and the FIFO is non-empty
//   SEND  | a word is held; presents beat idx until the last beat is accepted
module cr_kme_fifo_reader #(
    parameter int DATA_SIZE = 83,
    parameter int BEAT_W    = 32,
    parameter int COUNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_SIZE-1:0] fifo_out,
    input  logic                 fifo_out_valid,
    output logic                 fifo_out_ack,
    input  logic                 enable,
    output logic [BEAT_W-1:0]    beat_data,
    output logic                 beat_valid,
    output logic                 beat_sop,
    output logic                 beat_eop,
    input  logic                 beat_ready,
    output logic                 busy,
    output logic [COUNT_W-1:0]   words_drained
);

    localparam int NUM_BEATS = (DATA_SIZE + BEAT_W - 1) / BEAT_W;
    localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int PAD_W     = NUM_BEATS * BEAT_W;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]           state;
    logic [DATA_SIZE-1:0] hold;
    logic [IDX_W-1:0]     idx;
    logic [PAD_W-1:0]     hold_pad;
    logic                 last;
    logic                 hs;
    logic                 pop;

    // Zero-extend so the final beat reads zeros above DATA_SIZE-1.
    assign hold_pad = PAD_W'(hold);

    assign last       = (idx == IDX_W'(NUM_BEATS - 1));
    assign beat_valid = (state == ST_SEND);
    assign hs         = beat_valid & beat_ready;
    assign busy       = (state == ST_SEND);

    // rst_n gating keeps the FIFO from being popped while the block is held in reset.
    assign pop = rst_n & enable & fifo_out_valid &
                 ((state == ST_IDLE) | (hs & last));

    assign fifo_out_ack = pop;

    always_comb begin
        beat_data = '0;
        beat_sop  = 1'b0;
        beat_eop  = 1'b0;
        if (state == ST_SEND) begin
            beat_data = hold_pad[idx*BEAT_W +: BEAT_W];
            beat_sop  = (idx == '0);
            beat_eop  = last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            hold          <= '0;
            idx           <= '0;
            words_drained <= '0;
        end else begin
            if (pop) begin
                hold  <= fifo_out;
                idx   <= '0;
                state <= ST_SEND;
            end else if (hs) begin
                if (last) begin
                    state <= ST_IDLE;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (hs && last) begin
                words_drained <= words_drained + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cr_kme_fifo_reader.sv
// Bench for cr_kme_fifo_reader: a queue-based FIFO model feeds the reader and a
// beat scoreboard, filled when words are queued, is checked on every handshake.
module tb_cr_kme_fifo_reader;

    localparam int DATA_SIZE = 83;
    localparam int BEAT_W    = 32;
    localparam int COUNT_W   = 4;
    localparam int NB        = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DATA_SIZE-1:0] fifo_out;
    logic                 fifo_out_valid;
    logic                 fifo_out_ack;
    logic                 enable;
    logic [BEAT_W-1:0]    beat_data;
    logic                 beat_valid;
    logic                 beat_sop;
    logic                 beat_eop;
    logic                 beat_ready;
    logic                 busy;
    logic [COUNT_W-1:0]   words_drained;

    cr_kme_fifo_reader #(
        .DATA_SIZE (DATA_SIZE),
        .BEAT_W    (BEAT_W),
        .COUNT_W   (COUNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_out       (fifo_out),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ack   (fifo_out_ack),
        .enable         (enable),
        .beat_data      (beat_data),
        .beat_valid     (beat_valid),
        .beat_sop       (beat_sop),
        .beat_eop       (beat_eop),
        .beat_ready     (beat_ready),
        .busy           (busy),
        .words_drained  (words_drained)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_cnt = 0;
    int hs_cnt  = 0;
    int first_hs_cyc = -1;
    int last_hs_cyc  = -1;
    int exp_count    = 0;
    logic prev_ack = 1'b0;
    logic pop_s;

    logic [DATA_SIZE-1:0] fifo_q[$];
    logic [BEAT_W+1:0]    sb[$];   // {sop, eop, data}

    assign fifo_out_valid = (fifo_q.size() > 0);
    assign fifo_out       = (fifo_q.size() > 0) ? fifo_q[0] : '0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: the pop takes effect just after the edge on which ack was high.
    always @(posedge clk) begin
        pop_s = fifo_out_ack;
        #1;
        if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (fifo_out_ack && !fifo_out_valid) begin
                bad++;
                $display("FAIL ack_underflow: ack=%0b valid=%0b required ack=0", fifo_out_ack, fifo_out_valid);
            end
            if (prev_ack) begin
                total++;
                if (!(beat_valid && beat_sop)) begin
                    bad++;
                    $display("FAIL ack_latency: valid=%0b sop=%0b required 1/1 cycle after ack", beat_valid, beat_sop);
                end
            end
            if (beat_valid && beat_ready) begin
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: data=%h sop=%0b eop=%0b required none", beat_data, beat_sop, beat_eop);
                end else begin
                    logic [BEAT_W+1:0] e;
                    e = sb.pop_front();
                    if ({beat_sop, beat_eop, beat_data} !== e) begin
                        bad++;
                        $display("FAIL beat: got sop=%0b eop=%0b data=%h required sop=%0b eop=%0b data=%h",
                                 beat_sop, beat_eop, beat_data, e[BEAT_W+1], e[BEAT_W], e[BEAT_W-1:0]);
                    end
                end
            end
            if (fifo_out_ack) ack_cnt++;
            prev_ack = fifo_out_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic push_word(input logic [DATA_SIZE-1:0] w);
        logic [NB*BEAT_W-1:0] p;
        p = (NB*BEAT_W)'(w);
        for (int b = 0; b < NB; b++)
            sb.push_back({(b == 0), (b == NB-1), p[b*BEAT_W +: BEAT_W]});
        fifo_q.push_back(w);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((sb.size() != 0 || fifo_q.size() != 0 || busy) && k < 200) begin
            step(1);
            k++;
        end
        total++;
        if (k >= 200) begin
            bad++;
            $display("FAIL %s_timeout: sb=%0d fifo=%0d busy=%0b required drained", name, sb.size(), fifo_q.size(), busy);
        end
    endtask

    task automatic wait_beat1(input string name);
        int k = 0;
        while (!(beat_valid && !beat_sop && !beat_eop) && k < 50) begin
            step(1);
            k++;
        end
        total++;
        if (k >= 50) begin
            bad++;
            $display("FAIL %s_beat1_timeout: valid=%0b sop=%0b eop=%0b required beat 1", name, beat_valid, beat_sop, beat_eop);
        end
    endtask

    task automatic check_count(input string name);
        total++;
        if (words_drained !== COUNT_W'(exp_count)) begin
            bad++;
            $display("FAIL %s_count: got %0d required %0d", name, words_drained, exp_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; beat_ready = 1'b1;
        fifo_q.push_back(83'h1234);
        step(2);
        total++;
        if ({fifo_out_ack, beat_valid, busy, beat_sop, beat_eop} !== 5'b0 || beat_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%0b valid=%0b busy=%0b sop=%0b eop=%0b data=%h required all 0",
                     fifo_out_ack, beat_valid, busy, beat_sop, beat_eop, beat_data);
        end
        @(posedge clk);
        exp_count = 0;
        check_count("reset");
        enable = 1'b0;
        fifo_q.delete();
        #1;
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        ack_cnt = 0;
        beat_ready = 1'b1;
        push_word(83'h7_FFFF_0000_0001_DEAD_BEEF);
        enable = 1'b1;
        wait_drain("single");
        exp_count = (exp_count + 1) % 16;
        check_count("single");
        total++;
        if (ack_cnt !== 1) begin
            bad++;
            $display("FAIL single_acks: got %0d required 1", ack_cnt);
        end
    endtask

    task automatic test_backpressure();
        push_word(83'h7_FFFF_0000_0001_DEAD_BEEF);
        wait_beat1("bp");
        beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (!beat_valid || beat_data !== 32'h0000_0001 || fifo_out_ack || beat_sop || beat_eop) begin
                bad++;
                $display("FAIL bp_hold: valid=%0b data=%h ack=%0b sop=%0b eop=%0b required 1/00000001/0/0/0",
                         beat_valid, beat_data, fifo_out_ack, beat_sop, beat_eop);
            end
        end
        beat_ready = 1'b1;
        wait_drain("bp");
        exp_count = (exp_count + 1) % 16;
        check_count("bp");
    endtask

    task automatic test_back_to_back();
        enable = 1'b0;
        beat_ready = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++)
            push_word({$urandom(), $urandom(), $urandom()});
        ack_cnt = 0; hs_cnt = 0; first_hs_cyc = -1; last_hs_cyc = -1;
        enable = 1'b1;
        wait_drain("b2b");
        exp_count = (exp_count + 4) % 16;
        check_count("b2b");
        total++;
        if (ack_cnt !== 4 || hs_cnt !== 12 || (last_hs_cyc - first_hs_cyc) !== 11) begin
            bad++;
            $display("FAIL b2b_contig: acks=%0d beats=%0d span=%0d required 4/12/11",
                     ack_cnt, hs_cnt, last_hs_cyc - first_hs_cyc);
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        beat_ready = 1'b1;
        step(1);
        push_word(83'h1_2345_6789_ABCD_EF01_2345);
        push_word(83'h5_5555_AAAA_AAAA_5555_5555);
        ack_cnt = 0;
        enable = 1'b1;
        wait_beat1("en");
        enable = 1'b0;
        step(5);
        total++;
        if (busy || beat_valid || ack_cnt !== 1 || fifo_q.size() !== 1 || sb.size() !== 3) begin
            bad++;
            $display("FAIL en_drop: busy=%0b valid=%0b acks=%0d fifo=%0d sb=%0d required 0/0/1/1/3",
                     busy, beat_valid, ack_cnt, fifo_q.size(), sb.size());
        end
        exp_count = (exp_count + 1) % 16;
        check_count("en_drop");
        enable = 1'b1;
        wait_drain("en");
        exp_count = (exp_count + 1) % 16;
        check_count("en_resume");
        total++;
        if (ack_cnt !== 2) begin
            bad++;
            $display("FAIL en_resume_acks: got %0d required 2", ack_cnt);
        end
    endtask

    task automatic test_reset_wrap();
        enable = 1'b1;
        beat_ready = 1'b1;
        push_word(83'h0_0F0F_1111_2222_3333_4444);
        wait_beat1("rst");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        exp_count = 0;
        total++;
        if (busy || beat_valid) begin
            bad++;
            $display("FAIL midreset_idle: busy=%0b valid=%0b required 0/0", busy, beat_valid);
        end
        check_count("midreset");
        for (int i = 0; i < 17; i++)
            push_word({$urandom(), $urandom(), $urandom()});
        wait_drain("wrap");
        exp_count = 17 % 16;
        check_count("wrap");
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; beat_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_reset_wrap();
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
